// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall/flush scheduler for the r200 core
//
// Sequences the IF/ID, ID/EX and EX/MEM pipeline registers:
//   - load-use hazard: one-cycle bubble into ID/EX while PC and IF/ID hold
//   - data memory busy: whole front of the pipe holds until mem_ready
//   - taken branch / jump: flush wrong-path IF/ID (FLUSH_CYCLES cycles) and ID/EX
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1addr/id_rs2addr         source registers of the ID instruction
//   id_uses_rs1/id_uses_rs2       ID instruction actually reads rs1/rs2
//   ex_rdaddr/ex_regwr/ex_isload  destination info of the EX instruction
//   ex_brtaken/ex_willjmp         EX redirects the fetch stream
//   mem_req/mem_ready             MEM stage data-memory handshake
//   pc_stall..ex_mem_stall        hold controls
//   if_id_flush/id_ex_flush       invalidate controls
//   mem_timeout                   sticky: a memory wait reached MEM_TIMEOUT cycles
//   stall_cnt/flush_cnt           saturating perf counters
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1addr,
  input  logic [4:0]  id_rs2addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rdaddr,
  input  logic        ex_regwr,
  input  logic        ex_isload,
  input  logic        ex_brtaken,
  input  logic        ex_willjmp,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = MEM_TIMEOUT[7:0];
  localparam logic [1:0] FLUSH_INIT  = 2'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  flush_ctr_q, flush_ctr_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic memwait, redirect, loaduse;
  logic s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex;
  logic flush_event;
  logic [7:0] wait_inc;

  assign memwait  = mem_req & ~mem_ready;
  assign redirect = ex_brtaken | ex_willjmp;
  assign loaduse  = ex_isload & ex_regwr & (ex_rdaddr != 5'd0) &
                    ((id_uses_rs1 & (id_rs1addr == ex_rdaddr)) |
                     (id_uses_rs2 & (id_rs2addr == ex_rdaddr)));

  // Counter is zero outside MEM_WAIT, so the entry cycle counts as the first wait cycle.
  assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = 8'd0;
    flush_ctr_d = flush_ctr_q;
    timeout_d   = timeout_q;
    s_pc        = 1'b0;
    s_ifid      = 1'b0;
    s_idex      = 1'b0;
    s_exmem     = 1'b0;
    f_ifid      = 1'b0;
    f_idex      = 1'b0;
    flush_event = 1'b0;

    if (memwait || (state_q == MEM_WAIT && !mem_ready)) begin
      // Holding for memory; redirect/loaduse wait until the access completes.
      s_pc       = 1'b1;
      s_ifid     = 1'b1;
      s_idex     = 1'b1;
      s_exmem    = 1'b1;
      wait_cnt_d = wait_inc;
      state_d    = MEM_WAIT;
      if (wait_inc == TIMEOUT_VAL) begin
        timeout_d = 1'b1;
      end
    end else if (redirect) begin
      f_ifid      = 1'b1;
      f_idex      = 1'b1;
      flush_event = 1'b1;
      flush_ctr_d = FLUSH_INIT;
      state_d     = (FLUSH_CYCLES > 1) ? REDIRECT : RUN;
    end else if (state_q == REDIRECT) begin
      // ID holds a wrong-path instruction here, so any loaduse is ignored.
      f_ifid = 1'b1;
      if (flush_ctr_q <= 2'd1) begin
        state_d = RUN;
      end else begin
        flush_ctr_d = flush_ctr_q - 2'd1;
      end
    end else if (loaduse && state_q != LOAD_USE) begin
      s_pc    = 1'b1;
      s_ifid  = 1'b1;
      s_idex  = 1'b1;
      state_d = LOAD_USE;
    end else begin
      state_d = RUN;
    end

    stall_cnt_d = (s_pc && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush_event && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      flush_ctr_q <= 2'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_ctr_q <= flush_ctr_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_stall     = s_pc    & ~rst;
  assign if_id_stall  = s_ifid  & ~rst;
  assign id_ex_stall  = s_idex  & ~rst;
  assign ex_mem_stall = s_exmem & ~rst;
  assign if_id_flush  = f_ifid  & ~rst;
  assign id_ex_flush  = f_idex  & ~rst;
  assign mem_timeout  = timeout_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed table-driven bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1addr, id_rs2addr, ex_rdaddr;
  logic        id_uses_rs1, id_uses_rs2, ex_regwr, ex_isload;
  logic        ex_brtaken, ex_willjmp, mem_req, mem_ready;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rdaddr(ex_rdaddr), .ex_regwr(ex_regwr), .ex_isload(ex_isload),
    .ex_brtaken(ex_brtaken), .ex_willjmp(ex_willjmp),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        regwr;
    logic        isload;
    logic        br;
    logic        jmp;
    logic        req;
    logic        rdy;
    logic [3:0]  s;   // {pc, if_id, id_ex, ex_mem} stalls
    logic [1:0]  f;   // {if_id, id_ex} flushes
    logic        t;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic r, input logic [4:0] a1, input logic e1, input logic [4:0] a2, input logic e2,
    input logic [4:0] d, input logic w, input logic ld, input logic b, input logic j,
    input logic q, input logic y, input logic [3:0] s, input logic [1:0] f, input logic t,
    input logic [15:0] sc, input logic [15:0] fc);
    vec_t x;
    x.rst = r; x.rs1 = a1; x.u1 = e1; x.rs2 = a2; x.u2 = e2; x.rd = d; x.regwr = w;
    x.isload = ld; x.br = b; x.jmp = j; x.req = q; x.rdy = y;
    x.s = s; x.f = f; x.t = t; x.sc = sc; x.fc = fc;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    rst = x.rst; id_rs1addr = x.rs1; id_uses_rs1 = x.u1; id_rs2addr = x.rs2; id_uses_rs2 = x.u2;
    ex_rdaddr = x.rd; ex_regwr = x.regwr; ex_isload = x.isload; ex_brtaken = x.br;
    ex_willjmp = x.jmp; mem_req = x.req; mem_ready = x.rdy;
  endtask

  initial begin
    apply(v(1, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,0,0,0));
    repeat (2) @(posedge clk);

    //         rst rs1 u1 rs2 u2 rd w ld br jp rq ry  stalls   flush  t  sc fc
    tbl.push_back(v(1, 0,0, 0,0, 0,0,0, 1,0, 1,0, 4'b0000,2'b00,0, 0,0)); // 0 outputs forced low in reset
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,0, 0,0)); // 1 idle
    tbl.push_back(v(0, 0,0, 5,1, 5,1,1, 0,0, 0,0, 4'b1110,2'b00,0, 0,0)); // 2 load-use on rs2
    tbl.push_back(v(0, 0,0, 5,1, 5,1,1, 0,0, 0,0, 4'b0000,2'b00,0, 1,0)); // 3 no re-stall
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,0, 1,0)); // 4
    tbl.push_back(v(0, 0,1, 0,0, 0,1,1, 0,0, 0,0, 4'b0000,2'b00,0, 1,0)); // 5 rd=x0 never hazards
    tbl.push_back(v(0, 7,0, 0,0, 7,1,1, 0,0, 0,0, 4'b0000,2'b00,0, 1,0)); // 6 rs1 not used
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 1,0, 0,0, 4'b0000,2'b11,0, 1,0)); // 7 taken branch
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b10,0, 1,1)); // 8 second flush cycle
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,0, 1,1)); // 9 done
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 1,0, 4'b1111,2'b00,0, 1,1)); // 10 mem wait 1
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 1,0, 4'b1111,2'b00,0, 2,1)); // 11 mem wait 2
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 1,0, 4'b1111,2'b00,0, 3,1)); // 12 mem wait 3
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 1,0, 4'b1111,2'b00,1, 4,1)); // 13 timeout visible
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 1,1, 4'b0000,2'b00,1, 5,1)); // 14 ready: release
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,1, 5,1)); // 15 sticky timeout
    tbl.push_back(v(0, 0,0, 5,1, 5,1,1, 0,1, 0,0, 4'b0000,2'b11,1, 5,1)); // 16 jump beats load-use
    tbl.push_back(v(0, 0,0, 5,1, 5,1,1, 0,0, 0,0, 4'b0000,2'b10,1, 5,2)); // 17 load-use ignored
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 1,0, 1,0, 4'b1111,2'b00,1, 5,2)); // 18 memwait beats branch
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 1,0, 1,1, 4'b0000,2'b11,1, 6,2)); // 19 branch on ready
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 1,0, 0,0, 4'b0000,2'b11,1, 6,3)); // 20 restart in REDIRECT
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b10,1, 6,4)); // 21
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,1, 6,4)); // 22
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 1,0, 4'b1111,2'b00,1, 6,4)); // 23 enter MEM_WAIT
    tbl.push_back(v(1, 0,0, 0,0, 0,0,0, 0,0, 1,0, 4'b0000,2'b00,1, 7,4)); // 24 reset mid wait
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,0, 0,0)); // 25 cleared
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 1,0, 0,0, 4'b0000,2'b11,0, 0,0)); // 26 branch
    tbl.push_back(v(1, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,0, 0,1)); // 27 reset mid redirect
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,0, 0,0)); // 28 aborted
    tbl.push_back(v(0, 3,1, 0,0, 3,1,1, 0,0, 0,0, 4'b1110,2'b00,0, 0,0)); // 29 load-use on rs1
    tbl.push_back(v(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 4'b0000,2'b00,0, 1,0)); // 30
    tbl.push_back(v(0, 3,1, 0,0, 3,0,1, 0,0, 0,0, 4'b0000,2'b00,0, 1,0)); // 31 load without regwr

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1 apply(tbl[i]);
      @(negedge clk);
      chk("stalls", i, 16'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall}), 16'(tbl[i].s));
      chk("flushes", i, 16'({if_id_flush, id_ex_flush}), 16'(tbl[i].f));
      chk("mem_timeout", i, 16'(mem_timeout), 16'(tbl[i].t));
      chk("stall_cnt", i, stall_cnt, tbl[i].sc);
      chk("flush_cnt", i, flush_cnt, tbl[i].fc);
    end

    // Long memory wait drives stall_cnt (currently 1) into saturation.
    @(posedge clk);
    #1 apply(v(0, 0,0, 0,0, 0,0,0, 0,0, 1,0, 4'b0000,2'b00,0, 0,0));
    repeat (65533) @(posedge clk);
    @(negedge clk);
    chk("stall_cnt_fffe", 100, stall_cnt, 16'hFFFE);
    @(negedge clk);
    chk("stall_cnt_sat", 101, stall_cnt, 16'hFFFF);
    repeat (4466) @(posedge clk);
    @(negedge clk);
    chk("stall_cnt_hold", 102, stall_cnt, 16'hFFFF);
    chk("long_wait_stall", 103, 16'(ex_mem_stall), 16'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("long_wait_release", 104, 16'(pc_stall), 16'd0);
    chk("timeout_long", 105, 16'(mem_timeout), 16'd1);
    @(posedge clk);
    #1 mem_req = 1'b0;
    @(negedge clk);
    chk("stall_cnt_final", 106, stall_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall scheduler for the five-stage r200 core. Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and sequences them: detects load-use hazards, holds the pipe while data memory is busy, and flushes wrong-path instructions on taken branches and jumps. Also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- FLUSH_CYCLES, 2, total consecutive cycles if_id_flush is asserted per redirect (range 1..4)
- MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout is raised (8-bit)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- id_rs1addr  in  5  rs1 of instruction in ID
- id_rs2addr  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rdaddr  in  5  destination of instruction in EX
- ex_regwr  in  1  EX instruction writes the register file
- ex_isload  in  1  EX instruction is a load
- ex_brtaken  in  1  EX branch resolved taken (qualified by ex_isbr upstream)
- ex_willjmp  in  1  EX instruction is JAL/JALR
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- id_ex_stall  out  1  ID/EX inserts bubble
- ex_mem_stall  out  1  hold EX/MEM and EX stage
- if_id_flush  out  1  invalidate IF/ID
- id_ex_flush  out  1  invalidate ID/EX
- mem_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT
- stall_cnt  out  16  saturating count of cycles with pc_stall=1
- flush_cnt  out  16  saturating count of redirect events

## Operation
- FSM states: RUN, LOAD_USE, MEM_WAIT, REDIRECT. State, wait counter (8-bit), flush counter (2-bit), perf counters are registered; stall/flush outputs are combinational from state and inputs.
- Event definitions: memwait = mem_req & !mem_ready; redirect = ex_brtaken | ex_willjmp; loaduse = ex_isload & ex_regwr & ex_rdaddr!=0 & ((id_uses_rs1 & id_rs1addr==ex_rdaddr) | (id_uses_rs2 & id_rs2addr==ex_rdaddr)).
- Priority in RUN/LOAD_USE/REDIRECT: memwait > redirect > loaduse.
- memwait: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall all 1; no flush; next state MEM_WAIT.
- MEM_WAIT: same four stalls held while mem_ready=0; wait counter increments, saturates at 255; when counter reaches MEM_TIMEOUT set mem_timeout (sticky until rst), keep waiting. On mem_ready=1: stalls drop that cycle, counter clears, next RUN. Redirect/loaduse seen in that cycle are evaluated normally.
- redirect: if_id_flush=1, id_ex_flush=1, no stall; flush_cnt += 1; if FLUSH_CYCLES>1 next REDIRECT with flush counter = FLUSH_CYCLES-1, else RUN.
- REDIRECT: if_id_flush=1 only; counter decrements; at 1 -> RUN. A new redirect here restarts the sequence; loaduse ignored (ID is wrong-path).
- loaduse (RUN only): pc_stall, if_id_stall, id_ex_stall = 1 for exactly one cycle; next LOAD_USE. LOAD_USE releases all stalls (operand forwarded from MEM) and returns to RUN; a loaduse in LOAD_USE is not re-stalled.
- Redirect with loaduse same cycle: redirect only, no stall.
- Counters saturate at 16'hFFFF; never wrap.

## Timing
- rst=1 at posedge: state RUN, all counters 0, mem_timeout 0; while rst=1 all stall/flush outputs forced 0. Reset mid-MEM_WAIT or mid-REDIRECT aborts immediately.
- Load-use: stall visible in the same cycle as hazard; one bubble total.
- Redirect: flush same cycle as ex_brtaken/ex_willjmp; if_id_flush lasts FLUSH_CYCLES cycles.
- Memory wait: stall same cycle as memwait; released in the mem_ready cycle (zero-cycle exit latency).

## Test plan
- Load x5 in EX, ID reads rs2=x5 -> pc/if_id/id_ex stall high 1 cycle, then low; stall_cnt=1; repeat with ex_rdaddr=0 -> no stall.
- ex_brtaken pulse, FLUSH_CYCLES=2 -> cycle0 if_id_flush=1,id_ex_flush=1; cycle1 if_id_flush=1 only; cycle2 all 0; flush_cnt=1.
- mem_req=1, mem_ready=0 for 4 cycles then 1 -> four stalls high cycles 0-3, low cycle 4; stall_cnt=4.
- MEM_TIMEOUT=3, mem_ready low 6 cycles -> mem_timeout rises after 3rd wait-state cycle, stays 1 after exit until rst.
- Same cycle: loaduse + ex_willjmp -> flushes only, no stall; memwait + redirect -> stalls only, redirect flushed on mem_ready cycle.
- Assert rst during REDIRECT and MEM_WAIT -> all outputs 0 next cycle, counters 0; drive 70000 stall cycles -> stall_cnt holds 16'hFFFF.
